// File: rtl/dwn_pkg.sv
// Shared helpers for the streaming DWN group-sum: per-beat group masks
// and the group-sum width rule.
package dwn_pkg;

    localparam int DWN_MAX_PAR = 256;

    function automatic int dwn_sum_width(input int group_size);
        return $clog2(group_size) + 1;
    endfunction

    // Bit j is set when flat index beat*in_par+j falls inside group.
    function automatic logic [DWN_MAX_PAR-1:0] dwn_group_mask(
        input int beat,
        input int group,
        input int in_par,
        input int group_size
    );
        logic [DWN_MAX_PAR-1:0] m;
        m = '0;
        for (int j = 0; j < DWN_MAX_PAR; j++) begin
            if (j < in_par && ((beat * in_par + j) / group_size) == group) begin
                m[j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fixed_dwn_beat_popcount.sv
// Per-beat partial group counts: ones of one input beat that land in
// each group, selected by the constant masks for that beat index.
module fixed_dwn_beat_popcount
    import dwn_pkg::*;
#(
    parameter int IN_PAR = 3,
    parameter int NUM_GROUPS = 3,
    parameter int GROUP_SIZE = 4,
    parameter int BEATS = 4,
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int PC_W = $clog2(IN_PAR) + 1
) (
    input  logic [IN_PAR-1:0] data,
    input  logic [BW-1:0]     beat,
    output logic [PC_W-1:0]   counts [NUM_GROUPS]
);

    logic [IN_PAR-1:0] m;

    always_comb begin
        m = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            counts[g] = '0;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BW'(b)) begin
                for (int g = 0; g < NUM_GROUPS; g++) begin
                    m = IN_PAR'(dwn_group_mask(b, g, IN_PAR, GROUP_SIZE));
                    for (int j = 0; j < IN_PAR; j++) begin
                        if (m[j]) begin
                            counts[g] = counts[g] + PC_W'(data[j]);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fixed_dwn_groupsum_stream.sv
// Streaming DWN group-sum: accumulates per-group ones over BEATS input
// beats and presents all sums in one registered valid/ready beat.
module fixed_dwn_groupsum_stream
    import dwn_pkg::*;
#(
    parameter int INPUT_SIZE = 12,
    parameter int NUM_GROUPS = 3,
    parameter int IN_PAR = 3,
    localparam int GROUP_SIZE = INPUT_SIZE / NUM_GROUPS,
    localparam int SUM_W = dwn_sum_width(GROUP_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_PAR-1:0] data_in_0,
    input  logic              data_in_0_valid,
    output logic              data_in_0_ready,
    output logic [SUM_W-1:0]  data_out_0 [0:NUM_GROUPS-1],
    output logic              data_out_0_valid,
    input  logic              data_out_0_ready
);

    localparam int BEATS = INPUT_SIZE / IN_PAR;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PC_W = $clog2(IN_PAR) + 1;

    if (INPUT_SIZE % NUM_GROUPS != 0) begin : g_bad_groups
        $error("INPUT_SIZE must be a multiple of NUM_GROUPS");
    end
    if (INPUT_SIZE % IN_PAR != 0) begin : g_bad_par
        $error("INPUT_SIZE must be a multiple of IN_PAR");
    end

    logic [BW-1:0]    beat_cnt;
    logic [SUM_W-1:0] acc      [NUM_GROUPS];
    logic [SUM_W-1:0] sum_next [NUM_GROUPS];
    logic [PC_W-1:0]  pc       [NUM_GROUPS];
    logic             last;
    logic             fire;

    fixed_dwn_beat_popcount #(
        .IN_PAR     (IN_PAR),
        .NUM_GROUPS (NUM_GROUPS),
        .GROUP_SIZE (GROUP_SIZE),
        .BEATS      (BEATS)
    ) u_pc (
        .data   (data_in_0),
        .beat   (beat_cnt),
        .counts (pc)
    );

    // Only the closing beat needs room in the output register.
    assign last = (beat_cnt == BW'(BEATS - 1));
    assign data_in_0_ready = !last || !data_out_0_valid || data_out_0_ready;
    assign fire = data_in_0_valid && data_in_0_ready;

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            sum_next[g] = acc[g] + SUM_W'(pc[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            data_out_0_valid <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                acc[g] <= '0;
                data_out_0[g] <= '0;
            end
        end else begin
            if (fire) begin
                if (last) begin
                    beat_cnt <= '0;
                    for (int g = 0; g < NUM_GROUPS; g++) begin
                        acc[g] <= '0;
                        data_out_0[g] <= sum_next[g];
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    for (int g = 0; g < NUM_GROUPS; g++) begin
                        acc[g] <= sum_next[g];
                    end
                end
            end
            if (fire && last) begin
                data_out_0_valid <= 1'b1;
            end else if (data_out_0_ready) begin
                data_out_0_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_dwn_groupsum_stream.sv
// Bench for fixed_dwn_groupsum_stream: directed vectors, stall/reset
// sequences and randomized streams on a 4-beat and a 1-beat instance.
module tb_fixed_dwn_groupsum_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  in_a = '0;
    logic        in_v_a = 1'b0;
    logic        in_r_a;
    logic [2:0]  out_a [0:2];
    logic        out_v_a;
    logic        out_r_a = 1'b1;

    logic [11:0] in_b = '0;
    logic        in_v_b = 1'b0;
    logic        in_r_b;
    logic [2:0]  out_b [0:2];
    logic        out_v_b;
    logic        out_r_b = 1'b1;

    fixed_dwn_groupsum_stream #(
        .INPUT_SIZE (12), .NUM_GROUPS (3), .IN_PAR (3)
    ) dut_a (
        .clk (clk), .rst (rst),
        .data_in_0 (in_a), .data_in_0_valid (in_v_a),
        .data_in_0_ready (in_r_a),
        .data_out_0 (out_a), .data_out_0_valid (out_v_a),
        .data_out_0_ready (out_r_a)
    );

    fixed_dwn_groupsum_stream #(
        .INPUT_SIZE (12), .NUM_GROUPS (3), .IN_PAR (12)
    ) dut_b (
        .clk (clk), .rst (rst),
        .data_in_0 (in_b), .data_in_0_valid (in_v_b),
        .data_in_0_ready (in_r_b),
        .data_out_0 (out_b), .data_out_0_valid (out_v_b),
        .data_out_0_ready (out_r_b)
    );

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        logic [11:0] bits;
        logic [8:0]  sums;
    } vec_t;

    function automatic logic [8:0] model(input logic [11:0] bits);
        logic [8:0] s;
        logic [3:0] grp;
        s = '0;
        for (int g = 0; g < 3; g++) begin
            grp = bits[g*4 +: 4];
            s[g*3 +: 3] = 3'($countones(grp));
        end
        return s;
    endfunction

    function automatic logic [8:0] pack_a();
        return {out_a[2], out_a[1], out_a[0]};
    endfunction

    function automatic logic [8:0] pack_b();
        return {out_b[2], out_b[1], out_b[0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input logic [2:0] d);
        int t;
        in_a = d;
        in_v_a = 1'b1;
        t = 0;
        while (!in_r_a && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("beat_timeout", 0, 1);
        step();
        in_v_a = 1'b0;
    endtask

    task automatic send_a(input logic [11:0] bits);
        for (int b = 0; b < 4; b++) begin
            send_beat(bits[b*3 +: 3]);
        end
    endtask

    // Randomized-phase scoreboard state
    logic [8:0]  q_a[$];
    logic [8:0]  q_b[$];
    logic [11:0] cur_a = '0;
    int          beat_a = 0;
    int          cnt_in_a = 0, cnt_out_a = 0;
    int          cnt_in_b = 0, cnt_out_b = 0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0]  held_a = '0, held_b = '0;

    task automatic cycle_check();
        logic [8:0] e;
        @(negedge clk);
        if (stall_a) chk("hold_a", {out_v_a, pack_a()}, {1'b1, held_a});
        if (stall_b) chk("hold_b", {out_v_b, pack_b()}, {1'b1, held_b});
        stall_a = out_v_a && !out_r_a;
        stall_b = out_v_b && !out_r_b;
        held_a = pack_a();
        held_b = pack_b();
        if (out_v_a && out_r_a) begin
            if (q_a.size() == 0) begin
                chk("extra_out_a", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("rand_a", pack_a(), e);
            end
            cnt_out_a++;
        end
        if (out_v_b && out_r_b) begin
            if (q_b.size() == 0) begin
                chk("extra_out_b", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("rand_b", pack_b(), e);
            end
            cnt_out_b++;
        end
        if (in_v_a && in_r_a) begin
            cur_a[beat_a*3 +: 3] = in_a;
            beat_a++;
            if (beat_a == 4) begin
                q_a.push_back(model(cur_a));
                cnt_in_a++;
                beat_a = 0;
            end
        end
        if (in_v_b && in_r_b) begin
            q_b.push_back(model(in_b));
            cnt_in_b++;
        end
    endtask

    vec_t vecs [6];
    int   cyc;

    initial begin
        vecs[0] = '{12'hFFF, {3'd4, 3'd4, 3'd4}};
        vecs[1] = '{12'h111, {3'd1, 3'd1, 3'd1}};
        vecs[2] = '{12'h00E, {3'd0, 3'd0, 3'd3}};
        vecs[3] = '{12'hA5C, {3'd2, 3'd2, 3'd2}};
        vecs[4] = '{12'h0F0, {3'd0, 3'd4, 3'd0}};
        vecs[5] = '{12'h801, {3'd1, 3'd0, 3'd1}};

        step();
        step();
        chk("rst_valid_a", out_v_a, 0);
        chk("rst_data_a", pack_a(), 0);
        chk("rst_valid_b", out_v_b, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            send_a(vecs[i].bits);
            chk($sformatf("vec%0d_valid", i), out_v_a, 1);
            chk($sformatf("vec%0d_sums", i), pack_a(), vecs[i].sums);
            step();
            chk($sformatf("vec%0d_drop", i), out_v_a, 0);
        end

        // Full output register stalls only the closing beat
        out_r_a = 1'b0;
        send_a(12'h001);
        chk("stall_s1_valid", out_v_a, 1);
        send_beat(3'b000);
        send_beat(3'b000);
        send_beat(3'b000);
        in_a = 3'b111;
        in_v_a = 1'b1;
        chk("stall_ready0", in_r_a, 0);
        step();
        step();
        chk("stall_ready1", in_r_a, 0);
        chk("stall_hold", pack_a(), {3'd0, 3'd0, 3'd1});
        out_r_a = 1'b1;
        #1;
        chk("stall_release", in_r_a, 1);
        step();
        in_v_a = 1'b0;
        chk("swap_valid", out_v_a, 1);
        chk("swap_sums", pack_a(), {3'd3, 3'd0, 3'd0});
        step();
        chk("swap_drop", out_v_a, 0);
        chk("swap_keep", pack_a(), {3'd3, 3'd0, 3'd0});

        // Reset mid-sample discards the partial accumulation
        send_beat(3'b111);
        send_beat(3'b111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", out_v_a, 0);
        chk("mid_rst_data", pack_a(), 0);
        send_a(12'h000);
        chk("post_rst_valid", out_v_a, 1);
        chk("post_rst_sums", pack_a(), 0);
        step();

        // Randomized streams on both instances
        cyc = 0;
        while ((cnt_in_a < 1000 || cnt_in_b < 1000) && cyc < 40000) begin
            @(posedge clk);
            #1;
            in_v_a = ($urandom_range(0, 3) != 0);
            in_a = 3'($urandom);
            out_r_a = ($urandom_range(0, 2) != 0);
            in_v_b = ($urandom_range(0, 3) != 0);
            in_b = 12'($urandom);
            out_r_b = ($urandom_range(0, 2) != 0);
            cycle_check();
            cyc++;
        end
        if (cyc >= 40000) chk("rand_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_v_a = 1'b0;
            in_v_b = 1'b0;
            out_r_a = 1'b1;
            out_r_b = 1'b1;
            cycle_check();
        end
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        chk("count_a", cnt_out_a, cnt_in_a);
        chk("count_b", cnt_out_b, cnt_in_b);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
